// File: rtl/la_pkg.sv
`default_nettype none
// ============================================================================
// Package  : la_pkg
// Purpose  : Shared constants and types for the logic-analyser capture path.
//            The capture writer and the readback reader use the same memory
//            geometry, so both take their defaults from here.
// Contents : CAP_ADDR_W       - capture memory address width
//            CAP_DATA_W       - sample width (one bit per capture channel)
//            readback_state_t - readback controller states
// Revision : 1.0 - initial release
// ============================================================================
package la_pkg;

  localparam int CAP_ADDR_W = 18;
  localparam int CAP_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } readback_state_t;

endpackage
`default_nettype wire

// File: rtl/readback_fifo.sv
`default_nettype none
// ============================================================================
// Module   : readback_fifo
// Purpose  : Small synchronous FIFO used to absorb BRAM read latency. Entry 0
//            is always the head, so the head data comes straight from a
//            register and holds steady until it is popped.
// Ports    : clk        - clock
//            reset      - synchronous active-high reset
//            flush      - synchronous clear of all entries
//            push       - write push_data (ignored when full without a pop)
//            push_data  - write data
//            pop        - remove head entry (ignored when empty)
//            head_data  - current head entry
//            head_valid - FIFO holds at least one entry
//            count      - current occupancy, 0..DEPTH
// Revision : 1.0 - initial release
// ============================================================================
module readback_fifo
  import la_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int DATA_W = CAP_DATA_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         push,
  input  logic [DATA_W-1:0]            push_data,
  input  logic                         pop,
  output logic [DATA_W-1:0]            head_data,
  output logic                         head_valid,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  wr_idx;
  logic              do_pop;
  logic              do_push;

  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && ((count_q != CNT_W'(DEPTH)) || do_pop);

  // A simultaneous pop shifts everything down one slot, so the new entry
  // lands one position lower than it would otherwise.
  assign wr_idx = do_pop ? (count_q - CNT_W'(1)) : count_q;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_pop) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          mem[i] <= mem[i+1];
        end
      end
      // Written after the shift so the push wins on the shared slot.
      for (int i = 0; i < DEPTH; i++) begin
        if (do_push && (CNT_W'(i) == wr_idx)) begin
          mem[i] <= push_data;
        end
      end
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  assign head_data  = mem[0];
  assign head_valid = (count_q != '0);
  assign count      = count_q;

endmodule
`default_nettype wire

// File: rtl/capture_readback.sv
`default_nettype none
// ============================================================================
// Module   : capture_readback
// Purpose  : Streams a captured run out of BRAM, address 0 upward, on a
//            valid/ready byte stream. A credit-tracked prefetch FIFO of depth
//            RD_LAT+1 hides the BRAM read latency so backpressure can never
//            drop or repeat a sample.
// Ports    : clk, reset          - clock, synchronous active-high reset
//            start, abort        - begin a run (IDLE only) / cancel any run
//            length              - samples to read, clamped to 2**ADDR_W
//            busy, done          - run in progress / end-of-run pulse
//            sent_count          - samples accepted downstream this run
//            bram_en, bram_addr  - BRAM read request
//            bram_rdata          - BRAM data, RD_LAT cycles after bram_en
//            m_data, m_valid,
//            m_ready, m_last     - output byte stream
// Revision : 1.0 - initial release
// ============================================================================
module capture_readback
  import la_pkg::*;
#(
  parameter int ADDR_W = CAP_ADDR_W,
  parameter int DATA_W = CAP_DATA_W,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   sent_count,
  output logic              bram_en,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [DATA_W-1:0] bram_rdata,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last
);

  localparam int DEPTH  = RD_LAT + 1;
  localparam int LEN_W  = ADDR_W + 1;
  localparam int FCNT_W = $clog2(DEPTH + 1);
  localparam int OCC_W  = FCNT_W + 1;
  localparam logic [LEN_W-1:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  readback_state_t   state_q;
  readback_state_t   state_d;

  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  issued_q;
  logic [LEN_W-1:0]  sent_q;
  logic [LEN_W-1:0]  len_clamped;
  logic [RD_LAT-1:0] vld_sr;
  logic [RD_LAT:0]   vld_next;
  logic              zero_done_q;

  logic              issue;
  logic              pop;
  logic              push;
  logic              accept_start;
  logic              zero_start;
  logic              drain_done;
  logic              credit;

  logic [FCNT_W-1:0] fifo_count;
  logic              fifo_valid;
  logic [DATA_W-1:0] fifo_head;
  logic [OCC_W-1:0]  inflight;
  logic [OCC_W-1:0]  occupancy;

  // Clamping keeps the read address from wrapping back to 0.
  assign len_clamped = (length > MAX_LEN) ? MAX_LEN : length;

  // Abort outranks any transfer in the same cycle: the sample is not counted
  // and the FIFO is flushed anyway.
  assign pop  = fifo_valid && m_ready && !abort;
  assign push = vld_sr[RD_LAT-1] && !abort;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + OCC_W'(vld_sr[i]);
    end
  end

  // The slot freed by this cycle's pop is credited immediately; without it
  // the pipeline would stall every other cycle with m_ready held high.
  assign occupancy = inflight + OCC_W'(fifo_count) - OCC_W'(pop);
  assign credit    = (occupancy < OCC_W'(DEPTH));

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    issue        = 1'b0;
    accept_start = 1'b0;
    zero_start   = 1'b0;
    drain_done   = 1'b0;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (len_clamped != '0) begin
              accept_start = 1'b1;
              state_d      = READ;
            end else begin
              zero_start = 1'b1;
            end
          end
        end
        READ: begin
          if (credit) begin
            issue = 1'b1;
            if ((issued_q + LEN_W'(1)) == len_q) begin
              state_d = DRAIN;
            end
          end
        end
        DRAIN: begin
          if (sent_q == len_q) begin
            drain_done = 1'b1;
            state_d    = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Counters and read-return tracking
  // --------------------------------------------------------------------------
  assign vld_next = {vld_sr, issue};

  always_ff @(posedge clk) begin
    if (reset) begin
      len_q       <= '0;
      issued_q    <= '0;
      sent_q      <= '0;
      vld_sr      <= '0;
      zero_done_q <= 1'b0;
    end else begin
      zero_done_q <= zero_start;
      // Clearing the tracker on abort discards the returns still in flight.
      vld_sr      <= abort ? '0 : vld_next[RD_LAT-1:0];
      if (accept_start) begin
        len_q    <= len_clamped;
        issued_q <= '0;
        sent_q   <= '0;
      end else begin
        if (issue) begin
          issued_q <= issued_q + LEN_W'(1);
        end
        if (pop) begin
          sent_q <= sent_q + LEN_W'(1);
        end
      end
    end
  end

  readback_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (abort),
    .push       (push),
    .push_data  (bram_rdata),
    .pop        (pop),
    .head_data  (fifo_head),
    .head_valid (fifo_valid),
    .count      (fifo_count)
  );

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bram_en    = issue;
  assign bram_addr  = issued_q[ADDR_W-1:0];
  assign busy       = (state_q != IDLE) && !drain_done;
  assign done       = drain_done || zero_done_q;
  assign sent_count = sent_q;
  assign m_valid    = fifo_valid;
  assign m_data     = fifo_head;
  // The FIFO head is always the next sample to be sent, so its index is the
  // running transfer count.
  assign m_last     = fifo_valid && (sent_q == (len_q - LEN_W'(1)));

endmodule
`default_nettype wire

// File: tb/tb_capture_readback.sv
`default_nettype none
// ============================================================================
// Module   : tb_capture_readback
// Purpose  : Directed self-checking bench. Two readers run side by side from
//            shared control inputs, one with RD_LAT=1 and one with RD_LAT=2,
//            each with its own BRAM model returning addr[7:0] and its own
//            m_ready. A reduced ADDR_W keeps the full-depth runs short.
// Revision : 1.0 - initial release
// ============================================================================
module tb_capture_readback;
  import la_pkg::*;

  localparam int AW = 10;
  localparam int DW = 8;
  localparam int CW = AW + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          start;
  logic          abort;
  logic [CW-1:0] length;

  logic          busy      [2];
  logic          done      [2];
  logic          bram_en   [2];
  logic          m_valid   [2];
  logic          m_ready   [2];
  logic          m_last    [2];
  logic [CW-1:0] sent_count[2];
  logic [AW-1:0] bram_addr [2];
  logic [DW-1:0] bram_rdata[2];
  logic [DW-1:0] m_data    [2];
  logic [DW-1:0] rq0       [2];
  logic [DW-1:0] rq1       [2];

  capture_readback #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) u_dut_lat1 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .length(length),
    .busy(busy[0]), .done(done[0]), .sent_count(sent_count[0]),
    .bram_en(bram_en[0]), .bram_addr(bram_addr[0]), .bram_rdata(bram_rdata[0]),
    .m_data(m_data[0]), .m_valid(m_valid[0]), .m_ready(m_ready[0]), .m_last(m_last[0])
  );

  capture_readback #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(2)) u_dut_lat2 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .length(length),
    .busy(busy[1]), .done(done[1]), .sent_count(sent_count[1]),
    .bram_en(bram_en[1]), .bram_addr(bram_addr[1]), .bram_rdata(bram_rdata[1]),
    .m_data(m_data[1]), .m_valid(m_valid[1]), .m_ready(m_ready[1]), .m_last(m_last[1])
  );

  // BRAM models: contents are addr[7:0]; stage count matches each RD_LAT.
  always @(posedge clk) begin
    for (int l = 0; l < 2; l++) begin
      if (bram_en[l]) rq0[l] <= bram_addr[l][DW-1:0];
      rq1[l] <= rq0[l];
    end
  end
  assign bram_rdata[0] = rq0[0];
  assign bram_rdata[1] = rq1[1];

  // Bench-side observations, per lane
  int cyc;
  int start_c;
  int n_issue[2], n_xfer[2], max_out[2], errs[2], n_last[2], last_idx[2];
  int first_x[2], last_x[2], first_v[2], done_cnt[2], done_c[2], last_addr[2];
  int busy_seen[2], valid_seen[2], busy_at_done[2], rmode[2];
  logic          hold_pend[2];
  logic [DW-1:0] hold_d[2];
  logic          hold_l[2];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    start_c = -1;
    for (int l = 0; l < 2; l++) begin
      n_issue[l] = 0; n_xfer[l] = 0; max_out[l] = 0; errs[l] = 0;
      n_last[l] = 0; last_idx[l] = -1; first_x[l] = -1; last_x[l] = -1;
      first_v[l] = -1; done_cnt[l] = 0; done_c[l] = -1; last_addr[l] = -1;
      busy_seen[l] = 0; valid_seen[l] = 0; busy_at_done[l] = 0;
      hold_pend[l] = 1'b0;
    end
  endtask

  // Called at the falling edge: records what the next rising edge will do.
  task automatic sample();
    logic xfer;
    for (int l = 0; l < 2; l++) begin
      if (start && start_c < 0) start_c = cyc + 1;
      if (bram_en[l]) begin
        if (bram_addr[l] != AW'(n_issue[l])) errs[l]++;
        last_addr[l] = int'(bram_addr[l]);
        n_issue[l]++;
      end
      if (hold_pend[l]) begin
        if (!m_valid[l] || m_data[l] != hold_d[l] || m_last[l] != hold_l[l]) errs[l]++;
      end
      hold_pend[l] = m_valid[l] && !m_ready[l] && !abort && !reset;
      hold_d[l]    = m_data[l];
      hold_l[l]    = m_last[l];
      xfer = m_valid[l] && m_ready[l] && !abort && !reset;
      if (xfer) begin
        if (m_data[l] != n_xfer[l][DW-1:0]) errs[l]++;
        if (m_last[l]) begin
          n_last[l]++;
          last_idx[l] = n_xfer[l];
        end
        if (first_x[l] < 0) first_x[l] = cyc;
        last_x[l] = cyc;
        n_xfer[l]++;
      end
      if (n_issue[l] - n_xfer[l] > max_out[l]) max_out[l] = n_issue[l] - n_xfer[l];
      if (m_valid[l] && first_v[l] < 0) first_v[l] = cyc;
      if (busy[l]) busy_seen[l] = 1;
      if (m_valid[l]) valid_seen[l] = 1;
      if (done[l]) begin
        done_cnt[l]++;
        done_c[l] = cyc;
        busy_at_done[l] = int'(busy[l]);
      end
    end
  endtask

  // One clock: observe at the falling edge, then drive inputs 1 time unit
  // after the rising edge.
  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    cyc++;
    for (int l = 0; l < 2; l++) begin
      case (rmode[l])
        1: m_ready[l] = ($urandom_range(0, 99) < 30);
        2: m_ready[l] = (n_xfer[l] < 5);
        default: ;
      endcase
    end
  endtask

  task automatic pulse_start(input logic [CW-1:0] len);
    length = len;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!(done_cnt[0] > 0 && done_cnt[1] > 0) && n < budget) begin
      tick();
      n++;
    end
    check("wait_done_timeout", (n >= budget), 0);
  endtask

  task automatic check_run(input int l, input int len);
    check($sformatf("L%0d_xfers", l),    n_xfer[l],     len);
    check($sformatf("L%0d_errs", l),     errs[l],       0);
    check($sformatf("L%0d_last_cnt", l), n_last[l],     1);
    check($sformatf("L%0d_last_idx", l), last_idx[l],   len - 1);
    check($sformatf("L%0d_sent", l),     sent_count[l], len);
    check($sformatf("L%0d_done_cnt", l), done_cnt[l],   1);
    check($sformatf("L%0d_busy_done", l), busy_at_done[l], 0);
    check($sformatf("L%0d_issued", l),   n_issue[l],    len);
    check($sformatf("L%0d_max_out", l),  max_out[l],    l + 2);
  endtask

  task automatic check_quiet(input string tag);
    for (int l = 0; l < 2; l++) begin
      check($sformatf("L%0d_%s_ctl", l, tag),
            {busy[l], done[l], bram_en[l], m_valid[l], m_last[l]}, 0);
      check($sformatf("L%0d_%s_addr", l, tag), bram_addr[l], 0);
      check($sformatf("L%0d_%s_data", l, tag), m_data[l], 0);
      check($sformatf("L%0d_%s_sent", l, tag), sent_count[l], 0);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; length = '0; cyc = 0;
    for (int l = 0; l < 2; l++) begin
      m_ready[l] = 1'b0;
      rmode[l]   = 0;
    end
    clear_stats();

    // Reset state
    repeat (3) tick();
    check_quiet("rst");
    reset = 1'b0;
    tick();

    // 16 samples, m_ready high throughout
    m_ready[0] = 1'b1; m_ready[1] = 1'b1;
    clear_stats();
    pulse_start(CW'(16));
    wait_done(200);
    repeat (3) tick();
    for (int l = 0; l < 2; l++) begin
      check_run(l, 16);
      check($sformatf("L%0d_latency", l),   first_v[l] - start_c, l + 2);
      check($sformatf("L%0d_span", l),      last_x[l] - first_x[l], 15);
      check($sformatf("L%0d_done_ofs", l),  done_c[l] - last_x[l], 1);
      check($sformatf("L%0d_last_addr", l), last_addr[l], 15);
    end

    // Zero length: done next cycle, nothing else moves
    clear_stats();
    pulse_start(CW'(0));
    repeat (5) tick();
    for (int l = 0; l < 2; l++) begin
      check($sformatf("L%0d_z_done_cnt", l), done_cnt[l], 1);
      check($sformatf("L%0d_z_done_ofs", l), done_c[l] - start_c, 0);
      check($sformatf("L%0d_z_busy", l),     busy_seen[l], 0);
      check($sformatf("L%0d_z_issue", l),    n_issue[l], 0);
      check($sformatf("L%0d_z_valid", l),    valid_seen[l], 0);
    end

    // 64 samples, m_ready random at 30%
    clear_stats();
    rmode[0] = 1; rmode[1] = 1;
    pulse_start(CW'(64));
    wait_done(2000);
    repeat (3) tick();
    for (int l = 0; l < 2; l++) check_run(l, 64);
    rmode[0] = 0; rmode[1] = 0;
    m_ready[0] = 1'b1; m_ready[1] = 1'b1;

    // Full depth, then an over-range length that must clamp to full depth
    for (int k = 0; k < 2; k++) begin
      clear_stats();
      pulse_start((k == 0) ? CW'(1024) : CW'(11'h7FF));
      wait_done(3000);
      repeat (3) tick();
      for (int l = 0; l < 2; l++) begin
        check_run(l, 1024);
        check($sformatf("L%0d_full%0d_last_addr", l, k), last_addr[l], 1023);
      end
    end

    // Abort with the FIFO full after 5 transfers
    clear_stats();
    rmode[0] = 2; rmode[1] = 2;
    pulse_start(CW'(16));
    repeat (30) tick();
    for (int l = 0; l < 2; l++) begin
      check($sformatf("L%0d_ab_pre_xfer", l), n_xfer[l], 5);
      check($sformatf("L%0d_ab_full", l),     max_out[l], l + 2);
    end
    rmode[0] = 0; rmode[1] = 0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    for (int l = 0; l < 2; l++) begin
      check($sformatf("L%0d_ab_ctl", l), {m_valid[l], busy[l], bram_en[l]}, 0);
    end
    repeat (5) tick();
    for (int l = 0; l < 2; l++) begin
      check($sformatf("L%0d_ab_done", l), done_cnt[l], 0);
      check($sformatf("L%0d_ab_sent", l), sent_count[l], 5);
    end

    // Fresh run after abort: no stale data
    m_ready[0] = 1'b1; m_ready[1] = 1'b1;
    clear_stats();
    pulse_start(CW'(3));
    wait_done(100);
    repeat (3) tick();
    for (int l = 0; l < 2; l++) check_run(l, 3);

    // Mid-run start is ignored; mid-run reset returns everything to idle
    clear_stats();
    pulse_start(CW'(64));
    repeat (10) tick();
    pulse_start(CW'(5));
    repeat (5) tick();
    for (int l = 0; l < 2; l++) begin
      check($sformatf("L%0d_mid_busy", l), busy[l], 1);
      check($sformatf("L%0d_mid_sent", l), sent_count[l], 14 - l);
      check($sformatf("L%0d_mid_errs", l), errs[l], 0);
    end
    reset = 1'b1;
    tick();
    check_quiet("mrst");
    reset = 1'b0;
    repeat (4) tick();
    check_quiet("idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/capture_readback.md
Name: capture_readback

Overview:
Reader side of the capture memory. After a capture run, this block streams the stored samples out of BRAM in address order, starting at address 0, on a valid/ready byte stream. The stream feeds the host link, for example a UART transmitter. The block hides BRAM read latency with a small credit-tracked prefetch FIFO, so downstream backpressure never loses or duplicates a sample.

Parameters:
ADDR_W, 18, BRAM address width; memory depth is 2**ADDR_W.
DATA_W, 8, sample width; equals the capture channel count.
RD_LAT, 1, BRAM read latency in cycles from bram_en/bram_addr to valid bram_rdata; legal range 1..2.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle pulse; begins a readback; honoured only in IDLE
abort  in  1  level or pulse; cancels the readback in any state
length  in  ADDR_W+1  number of samples to read, 0..2**ADDR_W; sampled on start
busy  out  1  high from the cycle after an accepted start until the done pulse or an abort
done  out  1  single-cycle pulse after the last sample handshakes
sent_count  out  ADDR_W+1  samples accepted downstream in the current or last run
bram_en  out  1  BRAM read enable
bram_addr  out  ADDR_W  BRAM read address
bram_rdata  in  DATA_W  BRAM read data, valid RD_LAT cycles after the matching bram_en
m_data  out  DATA_W  stream data
m_valid  out  1  stream valid
m_ready  in  1  stream ready
m_last  out  1  high with the final sample of the run

Behaviour:
- Reset (synchronous, active-high, clk domain): state=IDLE. busy, done, bram_en, m_valid and m_last are 0; bram_addr, m_data and sent_count are 0; FIFO and pipeline are flushed.
- Handshake: a transfer occurs when m_valid && m_ready on a rising clk edge. Once m_valid is asserted, m_data and m_last hold until the transfer. m_valid must not depend combinationally on m_ready.
- Length: values above 2**ADDR_W clamp to 2**ADDR_W, so addresses never wrap.
- Prefetch FIFO: depth D = RD_LAT+1.
  - Credit rule: a read issues only when (in-flight reads + FIFO occupancy) < D, so returns never overflow.
  - Read data enters the FIFO on the cycle it returns, via a RD_LAT-deep valid shift register.
- FSM IDLE:
  - start with clamped length > 0: latch length; rd_addr=0; sent_count=0; go to READ.
  - start with length = 0: pulse done on the next cycle, stay in IDLE, busy stays 0.
- FSM READ:
  - Each cycle the credit rule allows, drive bram_en=1 and bram_addr=rd_addr, then increment rd_addr.
  - When issued reads == length, go to DRAIN. Best-case throughput is 1 sample/clk with m_ready held high.
- FSM DRAIN:
  - Issue no further reads.
  - When sent_count == length, pulse done for 1 cycle, drop busy in the same cycle, and go to IDLE.
- m_last is asserted when the FIFO head is sample index length-1.
- sent_count increments on every transfer and holds its final value in IDLE until the next accepted start.
- abort: takes priority over start and any transfer in the same cycle.
  - Next cycle: state=IDLE, FIFO flushed, in-flight returns discarded, m_valid=0, bram_en=0, busy=0.
  - No done pulse is produced; sent_count keeps the count reached at the abort.
- start while busy is ignored.
- reset asserted mid-run behaves as abort plus a full reset of all outputs.
- Latency: first m_valid appears RD_LAT+1 cycles after the accepted start, with m_ready=1.

Decomposition:
- Shared package la_pkg:
  - constants CAP_ADDR_W=18 and CAP_DATA_W=8, also used by the capture writer;
  - state enum readback_state_t {IDLE, READ, DRAIN}.
- One sub-module, readback_fifo: a parameterised synchronous FIFO of depth D with a registered head, plus count, push, pop and flush ports.
- FSM, credit counter and latency shift register stay in capture_readback.

Test Plan:
- BRAM model preloaded with addr[7:0]; start, length=16, m_ready=1 -> m_data 0x00..0x0F on 16 consecutive cycles after RD_LAT+1 latency; m_last only on 0x0F; done 1 cycle later; sent_count=16.
- length=0 -> done pulses next cycle; busy, bram_en and m_valid never assert.
- length=64, m_ready random at 30% -> every word transferred exactly once, in order; FIFO occupancy never exceeds D; bram_en never issues with credits exhausted. Run for RD_LAT=1 and RD_LAT=2.
- length=2**18 with m_ready=1 -> last bram_addr=0x3FFFF, no wrap; m_last on sample 262143; sent_count=0x40000. length=0x7FFFF clamps to the same result.
- abort after 5 transfers with m_ready stalled and FIFO full -> next cycle m_valid=0 and busy=0; no done; sent_count=5. A new start with length=3 then returns 0x00, 0x01, 0x02 with no stale data.
- start pulsed mid-run, then reset asserted mid-run -> the mid-run start is ignored; after reset, all outputs are 0 and state is IDLE.
